// File: rtl/cpu_ctrl_pkg.sv
// Stage encodings shared by the multicycle sequencer and the debug-port mux.
package cpu_ctrl_pkg;
   localparam int STAGE_W = 3;

   localparam logic [STAGE_W-1:0] ST_IF   = 3'd0;
   localparam logic [STAGE_W-1:0] ST_RF   = 3'd1;
   localparam logic [STAGE_W-1:0] ST_EX   = 3'd2;
   localparam logic [STAGE_W-1:0] ST_MEM  = 3'd3;
   localparam logic [STAGE_W-1:0] ST_WB   = 3'd4;
   localparam logic [STAGE_W-1:0] ST_HALT = 3'd5;

   typedef enum logic [STAGE_W-1:0] {
      S_IF   = ST_IF,
      S_RF   = ST_RF,
      S_EX   = ST_EX,
      S_MEM  = ST_MEM,
      S_WB   = ST_WB,
      S_HALT = ST_HALT
   } stateT;
endpackage

// File: rtl/mem_wait_timer.sv
// Data-memory wait counter: clears outside MEM, counts MEM cycles, flags the
// cycle in which the count reaches MEM_WAIT_MAX.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic nreset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam logic [7:0] LAST = 8'(MEM_WAIT_MAX - 1);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (nreset || clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   // This cycle's increment is the one that reaches the limit.
   assign expire = en && (count == LAST);
endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Multicycle IF/RF/EX/MEM/WB sequencer with memory wait states, squash,
// MEM timeout, halt/single-step debug control and a retired-instruction count.
module multicycle_stage_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32,
   parameter bit STEP_MODE_EN = 1'b1
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               imem_ready,
   input  logic               cond_pass,
   input  logic               is_mem_op,
   input  logic               is_branch,
   input  logic               writes_reg,
   input  logic               mem_ready,
   input  logic               halt_req,
   input  logic               step_req,
   output logic               fetch_go,
   output logic               regfetch_go,
   output logic               execute_go,
   output logic               dmem_go,
   output logic               wb_go,
   output logic               mem_req,
   output logic               pc_update,
   output logic               branch_take,
   output logic               retire,
   output logic               halted,
   output logic               mem_timeout,
   output logic [STAGE_W-1:0] stage,
   output logic [CNT_W-1:0]   retired_count
);
   stateT            state, stateNext;
   logic             branchLat, writesLat, stepLat, timeoutLat;
   logic [CNT_W-1:0] retiredCnt;
   logic             fetchC, rfC, exC, memC, wbC, pcC, takeC, retireC, haltedC;
   logic             timeoutSet, stepSet, timerExpire;
   logic             haltReqEff, boundaryHalt;

   assign haltReqEff   = STEP_MODE_EN && halt_req;
   assign boundaryHalt = haltReqEff || stepLat;

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
      .clk    (clk),
      .nreset (nreset),
      .clr    (state != S_MEM),
      .en     (memC),
      .expire (timerExpire)
   );

   always_comb begin
      stateNext  = state;
      fetchC     = 1'b0;
      rfC        = 1'b0;
      exC        = 1'b0;
      memC       = 1'b0;
      wbC        = 1'b0;
      pcC        = 1'b0;
      takeC      = 1'b0;
      retireC    = 1'b0;
      haltedC    = 1'b0;
      timeoutSet = 1'b0;
      stepSet    = 1'b0;
      case (state)
         S_IF: begin
            fetchC = 1'b1;
            if (imem_ready) stateNext = S_RF;
         end
         S_RF: begin
            rfC       = 1'b1;
            stateNext = S_EX;
         end
         S_EX: begin
            exC = 1'b1;
            if (!cond_pass) begin
               // Squashed instruction retires here with a sequential PC.
               retireC   = 1'b1;
               pcC       = 1'b1;
               stateNext = boundaryHalt ? S_HALT : S_IF;
            end else if (is_mem_op) begin
               stateNext = S_MEM;
            end else begin
               stateNext = S_WB;
            end
         end
         S_MEM: begin
            memC = 1'b1;
            if (mem_ready) begin
               stateNext = S_WB;
            end else if (timerExpire) begin
               timeoutSet = 1'b1;
               stateNext  = S_HALT;
            end
         end
         S_WB: begin
            wbC       = writesLat;
            pcC       = 1'b1;
            takeC     = branchLat;
            retireC   = 1'b1;
            stateNext = boundaryHalt ? S_HALT : S_IF;
         end
         S_HALT: begin
            haltedC = 1'b1;
            if (!timeoutLat) begin
               if (STEP_MODE_EN && step_req) begin
                  stepSet   = 1'b1;
                  stateNext = S_IF;
               end else if (!haltReqEff) begin
                  stateNext = S_IF;
               end
            end
         end
         default: stateNext = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         state      <= S_IF;
         branchLat  <= 1'b0;
         writesLat  <= 1'b0;
         stepLat    <= 1'b0;
         timeoutLat <= 1'b0;
         retiredCnt <= '0;
      end else begin
         state <= stateNext;
         if (state == S_EX) begin
            branchLat <= is_branch;
            writesLat <= writes_reg;
         end
         if (retireC) retiredCnt <= retiredCnt + CNT_W'(1);
         if (timeoutSet) timeoutLat <= 1'b1;
         if (stepSet) begin
            stepLat <= 1'b1;
         end else if (stateNext == S_HALT && state != S_HALT) begin
            stepLat <= 1'b0;
         end
      end
   end

   // Every output is forced low while reset is held.
   assign fetch_go      = fetchC  && !nreset;
   assign regfetch_go   = rfC     && !nreset;
   assign execute_go    = exC     && !nreset;
   assign dmem_go       = memC    && !nreset;
   assign mem_req       = memC    && !nreset;
   assign wb_go         = wbC     && !nreset;
   assign pc_update     = pcC     && !nreset;
   assign branch_take   = takeC   && !nreset;
   assign retire        = retireC && !nreset;
   assign halted        = haltedC && !nreset;
   assign mem_timeout   = timeoutLat && !nreset;
   assign stage         = nreset ? ST_IF : state;
   assign retired_count = nreset ? '0 : retiredCnt;
endmodule
